cim_input_loader: RTL and testbench
===================================

CIM_INPUT_LOADER -- requirements
Module: cim_input_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of one FIFO lane word.
REQ-002 Parameter NUM_WORDS, default 4, SHALL set the number of FIFO reads per CIM input vector.
REQ-003 Parameter ADDR_CIM_IN_WIDTH, default 8, SHALL set the width of the CIM input row address.
REQ-004 CLK_RD  input  1  SHALL be the single clock; all state on its rising edge.
REQ-005 RST_RD  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 start  input  1  SHALL be a one-cycle request to begin a load job.
REQ-007 vec_num  input  8  SHALL be the number of vectors in the job, sampled at start.
REQ-008 base_addr  input  ADDR_CIM_IN_WIDTH  SHALL be the first CIM row address, sampled at start.
REQ-009 col_en  input  1  SHALL select column-extension mode, sampled at start.
REQ-010 empty  input  2  SHALL be the per-FIFO empty flags of the upstream dual input FIFO.
REQ-011 RD_DATA  input  2*DATA_WIDTH  SHALL be the upstream read data, lane 0 in [31:0], lane 1 in [63:32].
REQ-012 RD_EN  output  2  SHALL be the per-FIFO read enables to the upstream FIFO.
REQ-013 reg_en_flag  output  2  SHALL be the upstream read-data gating flags.
REQ-014 cim_in_data  output  2*NUM_WORDS*DATA_WIDTH  SHALL be the assembled vector.
REQ-015 cim_in_addr  output  ADDR_CIM_IN_WIDTH  SHALL be the row address for cim_in_data.
REQ-016 cim_in_valid  output  1 / cim_in_ready  input  1  SHALL form a valid/ready handshake.
REQ-017 busy  output  1  SHALL be high while not IDLE; done  output  1  SHALL pulse one cycle at job end.

Function
REQ-018 FSM states SHALL be IDLE, READ, CAPTURE, PRESENT, FINISH.
REQ-019 IDLE: start=1 with vec_num!=0 -> READ; with vec_num=0 -> FINISH; start outside IDLE SHALL be ignored.
REQ-020 READ: issue read only when empty==2'b00; else stall in READ with RD_EN=0 (no timeout).
REQ-021 Normal mode read SHALL drive RD_EN=2'b11; col_en mode read SHALL drive RD_EN=2'b01.
REQ-022 RD_EN SHALL be high exactly one cycle per read; next state CAPTURE.
REQ-023 Upstream read latency is 1 cycle: in CAPTURE reg_en_flag SHALL be 2'b11 and RD_DATA captured.
REQ-024 Word k (0..NUM_WORDS-1) SHALL load lane0 into cim_in_data[k*32+:32], lane1 into [(NUM_WORDS+k)*32+:32].
REQ-025 In col_en mode lane1 word SHALL be {28'b0, RD_DATA[35:32]}.
REQ-026 After capture: word count<NUM_WORDS-1 -> READ (count+1); else -> PRESENT, count cleared.
REQ-027 PRESENT: cim_in_valid=1, cim_in_data and cim_in_addr stable until cim_in_ready=1.
REQ-028 Ready may precede valid; transfer occurs on the cycle valid&ready are both 1.
REQ-029 On transfer: vector count+1, cim_in_addr+1 (wraps max->0); remaining vectors -> READ, else FINISH.
REQ-030 FINISH: done=1 for one cycle, then IDLE; busy low in IDLE only.
REQ-031 Minimum latency per vector SHALL be 2*NUM_WORDS+1 cycles with FIFOs non-empty and ready high.
REQ-032 Outside CAPTURE reg_en_flag SHALL be 2'b00; outside READ RD_EN SHALL be 2'b00.

Reset
REQ-033 RST_RD SHALL force IDLE and zero RD_EN, reg_en_flag, cim_in_data, cim_in_addr, cim_in_valid, busy, done, all counters.
REQ-034 Reset mid-job SHALL abandon the job; no further reads; upstream FIFO contents untouched.

Verification
REQ-035 Normal: vec_num=2, base_addr=8'hFE, FIFOs preloaded, ready=1 -> two vectors at addr FE, FF, then done pulse.
REQ-036 Wrap: base_addr=8'hFF, vec_num=2 -> cim_in_addr FF then 00.
REQ-037 Col mode: col_en=1, lane1 writes 36'hA_xxxxxxxx -> RD_EN only 2'b01, lane1 words =32'h0000000A.
REQ-038 Empty stall: empty[1]=1 during READ for 5 cycles -> RD_EN=0 for 5 cycles, data correct after refill.
REQ-039 Backpressure: ready low 10 cycles in PRESENT -> valid held, data/addr stable, no reads issued.
REQ-040 Reset in CAPTURE of vector 1 -> all outputs 0 next cycle, new start runs cleanly; vec_num=0 -> done 1 cycle after start, no RD_EN.

Source files
------------

// File: rtl/cim_input_loader.sv
// Loads NUM_WORDS reads from a dual-lane input FIFO into one wide CIM input vector
// and presents it with a valid/ready handshake, one job of vec_num vectors per start.
module cim_input_loader #(
    parameter int DATA_WIDTH        = 32,
    parameter int NUM_WORDS         = 4,
    parameter int ADDR_CIM_IN_WIDTH = 8
) (
    input  logic                                CLK_RD,
    input  logic                                RST_RD,
    input  logic                                start,
    input  logic [7:0]                          vec_num,
    input  logic [ADDR_CIM_IN_WIDTH-1:0]        base_addr,
    input  logic                                col_en,
    input  logic [1:0]                          empty,
    input  logic [2*DATA_WIDTH-1:0]             RD_DATA,
    output logic [1:0]                          RD_EN,
    output logic [1:0]                          reg_en_flag,
    output logic [2*NUM_WORDS*DATA_WIDTH-1:0]   cim_in_data,
    output logic [ADDR_CIM_IN_WIDTH-1:0]        cim_in_addr,
    output logic                                cim_in_valid,
    input  logic                                cim_in_ready,
    output logic                                busy,
    output logic                                done
);

    localparam int WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] READ    = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] PRESENT = 3'd3;
    localparam logic [2:0] FINISH  = 3'd4;

    logic [2:0]            state, state_nxt;
    logic [WCW-1:0]        word_cnt;
    logic [7:0]            vec_cnt;
    logic [7:0]            vec_num_r;
    logic                  col_r;
    logic                  last_word;
    logic                  last_vec;
    logic                  fifo_ready;
    logic [DATA_WIDTH-1:0] lane1_word;

    assign last_word  = (word_cnt == WCW'(NUM_WORDS - 1));
    assign last_vec   = ((vec_cnt + 8'd1) == vec_num_r);
    assign fifo_ready = (empty == 2'b00);

    // Column-extension mode carries only a 4-bit field on lane 1.
    assign lane1_word = col_r ? {{(DATA_WIDTH-4){1'b0}}, RD_DATA[DATA_WIDTH+3:DATA_WIDTH]}
                              : RD_DATA[2*DATA_WIDTH-1:DATA_WIDTH];

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned and infers a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (vec_num != 8'd0) ? READ : FINISH;
            READ:    if (fifo_ready) state_nxt = CAPTURE;
            CAPTURE: state_nxt = last_word ? PRESENT : READ;
            PRESENT: if (cim_in_ready) state_nxt = last_vec ? FINISH : READ;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reads and capture gating are decoded from state so they cannot outlive the cycle.
    assign RD_EN        = (state == READ && fifo_ready) ? (col_r ? 2'b01 : 2'b11) : 2'b00;
    assign reg_en_flag  = (state == CAPTURE) ? 2'b11 : 2'b00;
    assign cim_in_valid = (state == PRESENT);
    assign busy         = (state != IDLE);
    assign done         = (state == FINISH);

    always_ff @(posedge CLK_RD or posedge RST_RD) begin
        if (RST_RD) begin
            // NOTE: the assembled vector is a plain register, not a RAM, so it is reset
            // with the rest of the state to give a clean all-zero output after reset.
            state       <= IDLE;
            word_cnt    <= '0;
            vec_cnt     <= '0;
            vec_num_r   <= '0;
            col_r       <= 1'b0;
            cim_in_addr <= '0;
            cim_in_data <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_num_r   <= vec_num;
                        col_r       <= col_en;
                        cim_in_addr <= base_addr;
                        vec_cnt     <= '0;
                        word_cnt    <= '0;
                    end
                end
                CAPTURE: begin
                    for (int k = 0; k < NUM_WORDS; k++) begin
                        if (word_cnt == WCW'(k)) begin
                            cim_in_data[k*DATA_WIDTH +: DATA_WIDTH]             <= RD_DATA[DATA_WIDTH-1:0];
                            cim_in_data[(NUM_WORDS+k)*DATA_WIDTH +: DATA_WIDTH] <= lane1_word;
                        end
                    end
                    word_cnt <= last_word ? '0 : word_cnt + WCW'(1);
                end
                PRESENT: begin
                    if (cim_in_ready) begin
                        vec_cnt     <= vec_cnt + 8'd1;
                        cim_in_addr <= cim_in_addr + ADDR_CIM_IN_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_input_loader.sv
// Scoreboard bench for cim_input_loader: a behavioural dual FIFO feeds the DUT and
// expected vectors are queued when each job's FIFO data is generated.
module tb_cim_input_loader;

    localparam int DW     = 32;
    localparam int NW     = 4;
    localparam int AW     = 8;
    localparam int VW     = 2 * NW * DW;
    localparam int BUDGET = 500;

    typedef struct {
        logic [VW-1:0] data;
        logic [AW-1:0] addr;
    } vec_t;

    logic            CLK_RD = 1'b0;
    logic            RST_RD;
    logic            start;
    logic [7:0]      vec_num;
    logic [AW-1:0]   base_addr;
    logic            col_en;
    logic [1:0]      empty = 2'b11;
    logic [2*DW-1:0] RD_DATA;
    logic [1:0]      RD_EN;
    logic [1:0]      reg_en_flag;
    logic [VW-1:0]   cim_in_data;
    logic [AW-1:0]   cim_in_addr;
    logic            cim_in_valid;
    logic            cim_in_ready;
    logic            busy;
    logic            done;

    int n_checks = 0;
    int n_errors = 0;

    cim_input_loader #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .ADDR_CIM_IN_WIDTH(AW)) dut (
        .CLK_RD(CLK_RD), .RST_RD(RST_RD), .start(start), .vec_num(vec_num),
        .base_addr(base_addr), .col_en(col_en), .empty(empty), .RD_DATA(RD_DATA),
        .RD_EN(RD_EN), .reg_en_flag(reg_en_flag), .cim_in_data(cim_in_data),
        .cim_in_addr(cim_in_addr), .cim_in_valid(cim_in_valid),
        .cim_in_ready(cim_in_ready), .busy(busy), .done(done)
    );

    always #5 CLK_RD = ~CLK_RD;

    task automatic check(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Upstream FIFO model: one-cycle read latency, output register holds between reads.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] out0 = '0;
    logic [DW-1:0] out1 = '0;
    logic          hold_empty1 = 1'b0;
    logic          prime1 = 1'b0;
    logic [DW-1:0] prime_val = 32'h1234_567A;
    int            underflows = 0;
    int            rd1_count = 0;
    int            rd_any_count = 0;
    int            bad_flag = 0;
    int            done_count = 0;
    int            done_double = 0;
    logic          prev_done = 1'b0;

    assign RD_DATA = {out1, out0};

    always @(posedge CLK_RD) begin
        if (RD_EN[0]) begin
            if (q0.size() > 0) out0 <= q0.pop_front();
            else underflows++;
        end
        if (RD_EN[1]) begin
            if (q1.size() > 0) out1 <= q1.pop_front();
            else underflows++;
        end else if (prime1) begin
            out1 <= prime_val;
        end
    end

    always @(negedge CLK_RD) begin
        #1;
        empty = {hold_empty1 || (q1.size() == 0), q0.size() == 0};
    end

    vec_t sb[$];

    always @(negedge CLK_RD) begin
        vec_t e;
        if (!RST_RD) begin
            if (RD_EN[1]) rd1_count++;
            if (RD_EN != 2'b00) rd_any_count++;
            if (reg_en_flag != 2'b00 && reg_en_flag != 2'b11) bad_flag++;
            if (done) done_count++;
            if (done && prev_done) done_double++;
            prev_done = done;
            if (cim_in_valid && cim_in_ready) begin
                if (sb.size() == 0) begin
                    check("extra_vector", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("vec_data", cim_in_data, e.data);
                    check("vec_addr", VW'(cim_in_addr), VW'(e.addr));
                end
            end
        end else begin
            prev_done = 1'b0;
        end
    end

    // Generates FIFO contents for a job and the vectors they should assemble into.
    task automatic prepare_job(input int vn, input logic [AW-1:0] base, input logic col);
        vec_t          e;
        logic [DW-1:0] w0, w1;
        for (int v = 0; v < vn; v++) begin
            e.data = '0;
            e.addr = base + AW'(v);
            for (int k = 0; k < NW; k++) begin
                w0 = $urandom;
                w1 = $urandom;
                q0.push_back(w0);
                e.data[k*DW +: DW] = w0;
                if (col) begin
                    e.data[(NW+k)*DW +: DW] = {28'b0, prime_val[3:0]};
                end else begin
                    q1.push_back(w1);
                    e.data[(NW+k)*DW +: DW] = w1;
                end
            end
            sb.push_back(e);
        end
        if (col && q1.size() == 0) q1.push_back(32'h0BAD_F00D);
        @(negedge CLK_RD);
    endtask

    task automatic start_job(input int vn, input logic [AW-1:0] base, input logic col);
        vec_num   = 8'(vn);
        base_addr = base;
        col_en    = col;
        start     = 1'b1;
        @(negedge CLK_RD);
        start     = 1'b0;
        vec_num   = 8'hAA;
        col_en    = ~col;
    endtask

    task automatic wait_done(output int n, output int first_valid);
        n = 0;
        first_valid = -1;
        while (!done && n < BUDGET) begin
            if (cim_in_valid && first_valid < 0) first_valid = n;
            @(negedge CLK_RD);
            n++;
        end
        if (n >= BUDGET) check("done_timeout", 1, 0);
        @(negedge CLK_RD);
    endtask

    initial begin
        int n, first, dc, r1, ra, cnt, q0s, q1s;
        logic          held;
        logic [VW-1:0] snap_data;
        logic [AW-1:0] snap_addr;

        RST_RD       = 1'b1;
        start        = 1'b0;
        vec_num      = '0;
        base_addr    = '0;
        col_en       = 1'b0;
        cim_in_ready = 1'b1;
        repeat (3) @(negedge CLK_RD);
        check("rst_rd_en", VW'(RD_EN), 0);
        check("rst_outputs", VW'({busy, done, cim_in_valid, reg_en_flag}), 0);
        check("rst_data", cim_in_data, 0);
        check("rst_addr", VW'(cim_in_addr), 0);
        RST_RD = 1'b0;
        @(negedge CLK_RD);

        // Normal: two vectors at FE, FF; first vector after 2*NW+1 cycles counting the start cycle.
        dc = done_count;
        prepare_job(2, 8'hFE, 1'b0);
        start_job(2, 8'hFE, 1'b0);
        wait_done(n, first);
        check("normal_latency", VW'(first), VW'(2 * NW));
        check("normal_done_once", VW'(done_count - dc), 1);
        check("normal_sb_drain", VW'(sb.size()), 0);
        check("idle_after_job", VW'(busy), 0);

        // Address wraps from FF to 00.
        prepare_job(2, 8'hFF, 1'b0);
        start_job(2, 8'hFF, 1'b0);
        wait_done(n, first);
        check("wrap_sb_drain", VW'(sb.size()), 0);

        // Column mode: lane 1 never read, lane 1 words carry only the 4-bit field.
        r1     = rd1_count;
        prime1 = 1'b1;
        prepare_job(1, 8'h10, 1'b1);
        start_job(1, 8'h10, 1'b1);
        wait_done(n, first);
        prime1 = 1'b0;
        check("col_no_lane1_read", VW'(rd1_count - r1), 0);
        check("col_sb_drain", VW'(sb.size()), 0);
        q1.delete();

        // Empty stall: lane 1 reports empty for 5 cycles while the DUT sits in READ.
        prepare_job(1, 8'h20, 1'b0);
        start_job(1, 8'h20, 1'b0);
        n = 0;
        while (reg_en_flag != 2'b11 && n < BUDGET) begin @(negedge CLK_RD); n++; end
        check("stall_reach_capture", VW'(n < BUDGET), 1);
        hold_empty1 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_RD);
            if (RD_EN == 2'b00 && busy && reg_en_flag == 2'b00 && !cim_in_valid) cnt++;
        end
        hold_empty1 = 1'b0;
        check("stall_rd_en_low", VW'(cnt), 5);
        wait_done(n, first);
        check("stall_sb_drain", VW'(sb.size()), 0);

        // Backpressure: ready low for 10 cycles in PRESENT.
        cim_in_ready = 1'b0;
        prepare_job(1, 8'h30, 1'b0);
        start_job(1, 8'h30, 1'b0);
        n = 0;
        while (!cim_in_valid && n < BUDGET) begin @(negedge CLK_RD); n++; end
        check("bp_reach_present", VW'(n < BUDGET), 1);
        snap_data = cim_in_data;
        snap_addr = cim_in_addr;
        ra   = rd_any_count;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK_RD);
            if (!cim_in_valid || cim_in_data !== snap_data || cim_in_addr !== snap_addr) held = 1'b0;
        end
        check("bp_held_stable", VW'(held), 1);
        check("bp_no_reads", VW'(rd_any_count - ra), 0);
        cim_in_ready = 1'b1;
        wait_done(n, first);
        check("bp_sb_drain", VW'(sb.size()), 0);

        // Reset during CAPTURE of vector 1 abandons the job.
        prepare_job(2, 8'h40, 1'b0);
        start_job(2, 8'h40, 1'b0);
        n = 0;
        while (!(sb.size() == 1 && reg_en_flag == 2'b11) && n < BUDGET) begin @(negedge CLK_RD); n++; end
        check("rst_reach_capture", VW'(n < BUDGET), 1);
        RST_RD = 1'b1;
        #1;
        check("midrst_outputs", VW'({RD_EN, reg_en_flag, cim_in_valid, busy, done}), 0);
        check("midrst_data", cim_in_data, 0);
        check("midrst_addr", VW'(cim_in_addr), 0);
        q0s = q0.size();
        q1s = q1.size();
        repeat (2) @(negedge CLK_RD);
        RST_RD = 1'b0;
        repeat (3) @(negedge CLK_RD);
        check("midrst_fifo_untouched", VW'({q0.size(), q1.size()}), VW'({q0s, q1s}));
        check("midrst_idle", VW'(busy), 0);
        sb.delete();
        q0.delete();
        q1.delete();

        prepare_job(1, 8'h50, 1'b0);
        start_job(1, 8'h50, 1'b0);
        wait_done(n, first);
        check("post_rst_sb_drain", VW'(sb.size()), 0);

        // Zero-vector job: done in the cycle after start, no reads.
        ra = rd_any_count;
        dc = done_count;
        start_job(0, 8'h60, 1'b0);
        wait_done(n, first);
        check("zero_done_latency", VW'(n), 0);
        check("zero_no_reads", VW'(rd_any_count - ra), 0);
        check("zero_done_once", VW'(done_count - dc), 1);

        check("fifo_underflow", VW'(underflows), 0);
        check("reg_en_flag_legal", VW'(bad_flag), 0);
        check("done_single_cycle", VW'(done_double), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
